// File: rtl/tt_stim_sequencer.sv
// Stimulus/check sequencer for a two-input combinational cell: walks {A,B} through 00..11,
// samples Q at the end of each dwell and tallies mismatches. Optional TT_STIM_FAIL_CAPTURE_EN.
module tt_stim_sequencer #(
    parameter int unsigned DWELL  = 10,
    parameter logic [3:0]  EXP_TT = 4'b1000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       A_out,
    output logic       B_out,
    input  logic       Q_in,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [2:0] err_count,
`ifdef TT_STIM_FAIL_CAPTURE_EN
    output logic       fail_valid,
    output logic [1:0] fail_vec,
    output logic       fail_q,
`endif
    output logic [1:0] vec_idx
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    localparam logic [7:0] CNT_LAST = 8'(DWELL - 1);

    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [1:0] vec_q, vec_d;
    logic [2:0] err_q, err_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       pass_q, pass_d;
    logic       fval_q, fval_d;
    logic [1:0] fvec_q, fvec_d;
    logic       fq_q, fq_d;
    logic       mismatch;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        vec_d    = vec_q;
        err_d    = err_q;
        busy_d   = busy_q;
        done_d   = done_q;
        pass_d   = pass_q;
        fval_d   = fval_q;
        fvec_d   = fvec_q;
        fq_d     = fq_q;
        mismatch = (Q_in != EXP_TT[vec_q]);
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = S_RUN;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                    pass_d  = 1'b0;
                    vec_d   = 2'd0;
                    cnt_d   = 8'd0;
                    err_d   = 3'd0;
                    fval_d  = 1'b0;
                    fvec_d  = 2'd0;
                    fq_d    = 1'b0;
                end
            end
            S_RUN: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d = 8'd0;
                    err_d = err_q + {2'b00, mismatch};
                    // Only the first mismatch of a run is captured; later ones leave it frozen.
                    if (mismatch && !fval_q) begin
                        fval_d = 1'b1;
                        fvec_d = vec_q;
                        fq_d   = Q_in;
                    end
                    if (vec_q == 2'd3) begin
                        state_d = S_DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        pass_d  = (err_d == 3'd0);
                        vec_d   = 2'd0;
                    end else begin
                        vec_d = vec_q + 2'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 8'd0;
            vec_q   <= 2'd0;
            err_q   <= 3'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            fval_q  <= 1'b0;
            fvec_q  <= 2'd0;
            fq_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            vec_q   <= vec_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
            fval_q  <= fval_d;
            fvec_q  <= fvec_d;
            fq_q    <= fq_d;
        end
    end

    // vec_q returns to 0 outside RUN, so the cell inputs idle at 00.
    assign A_out     = vec_q[1];
    assign B_out     = vec_q[0];
    assign vec_idx   = vec_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign err_count = err_q;
`ifdef TT_STIM_FAIL_CAPTURE_EN
    assign fail_valid = fval_q;
    assign fail_vec   = fvec_q;
    assign fail_q     = fq_q;
`else
    logic unused_capture;
    assign unused_capture = ^{fval_q, fvec_q, fq_q};
`endif

endmodule
